// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: allocates tags at issue, collects CDB
// results, retires one entry per cycle in program order and raises a
// pipeline flush when a retiring branch turns out to be mispredicted.
// The all-ones tag means "no dependency" and is never allocated.
module reorder_buffer #(
   parameter int ROB_SIZE_WIDTH = 4,
   parameter int REG_NUM_WIDTH  = 5
) (
   input  logic                      clk_in,
   input  logic                      rst_in,
   input  logic                      rdy_in,
   input  logic                      issue_valid,
   input  logic [1:0]                issue_type,
   input  logic [REG_NUM_WIDTH-1:0]  issue_rd,
   input  logic                      issue_pred_taken,
   input  logic [31:0]               issue_alt_pc,
   output logic [ROB_SIZE_WIDTH-1:0] issue_tag_out,
   output logic                      full_out,
   input  logic                      cdb_valid,
   input  logic [ROB_SIZE_WIDTH-1:0] cdb_tag,
   input  logic [31:0]               cdb_value,
   input  logic                      cdb_taken,
   input  logic [ROB_SIZE_WIDTH-1:0] query1_tag,
   input  logic [ROB_SIZE_WIDTH-1:0] query2_tag,
   output logic                      query1_ready,
   output logic                      query2_ready,
   output logic [31:0]               query1_value,
   output logic [31:0]               query2_value,
   output logic                      commit_valid,
   output logic [REG_NUM_WIDTH-1:0]  commit_rd,
   output logic [31:0]               commit_value,
   output logic [ROB_SIZE_WIDTH-1:0] commit_tag,
   output logic                      store_commit_out,
   output logic                      flush_out,
   output logic [31:0]               redirect_pc_out
);

   localparam int DEPTH = (1 << ROB_SIZE_WIDTH) - 1;
   // All-ones doubles as the reserved tag and the capacity count.
   localparam logic [ROB_SIZE_WIDTH-1:0] NONE = '1;
   localparam logic [ROB_SIZE_WIDTH-1:0] LAST = NONE - ROB_SIZE_WIDTH'(1);
   localparam logic [1:0] TYPE_BRANCH = 2'd1;
   localparam logic [1:0] TYPE_STORE  = 2'd2;

   logic                     busy   [DEPTH];
   logic                     ready  [DEPTH];
   logic [1:0]               kind   [DEPTH];
   logic [REG_NUM_WIDTH-1:0] rd     [DEPTH];
   logic                     pred   [DEPTH];
   logic                     taken  [DEPTH];
   logic [31:0]              alt_pc [DEPTH];
   logic [31:0]              value  [DEPTH];

   logic [ROB_SIZE_WIDTH-1:0] head, tail, count;
   logic do_issue, do_retire, mispredict;

   function automatic logic [ROB_SIZE_WIDTH-1:0] next_ptr(input logic [ROB_SIZE_WIDTH-1:0] p);
      return (p == LAST) ? '0 : p + ROB_SIZE_WIDTH'(1);
   endfunction

   assign full_out      = (count == NONE);
   assign issue_tag_out = tail;
   assign do_issue      = issue_valid && !full_out;
   assign do_retire     = (count != '0) && busy[head] && ready[head];
   assign mispredict    = do_retire && (kind[head] == TYPE_BRANCH) && (taken[head] != pred[head]);

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
         logic alloc_hit, cdb_hit, retire_hit;
         assign alloc_hit  = do_issue && (tail == ROB_SIZE_WIDTH'(gi));
         assign retire_hit = do_retire && (head == ROB_SIZE_WIDTH'(gi));
         assign cdb_hit    = cdb_valid && (cdb_tag == ROB_SIZE_WIDTH'(gi)) && busy[gi] && !retire_hit;

         // Per-entry state: flush clears everything, otherwise retire/CDB/allocate.
         always_ff @(posedge clk_in) begin
            if (rst_in) begin
               busy[gi]  <= 1'b0;
               ready[gi] <= 1'b0;
            end else if (rdy_in) begin
               if (mispredict) begin
                  busy[gi]  <= 1'b0;
                  ready[gi] <= 1'b0;
               end else begin
                  if (retire_hit) begin
                     busy[gi]  <= 1'b0;
                     ready[gi] <= 1'b0;
                  end
                  if (cdb_hit) begin
                     ready[gi] <= 1'b1;
                     value[gi] <= cdb_value;
                     taken[gi] <= cdb_taken;
                  end
                  if (alloc_hit) begin
                     busy[gi]   <= 1'b1;
                     ready[gi]  <= 1'b0;
                     kind[gi]   <= issue_type;
                     rd[gi]     <= issue_rd;
                     pred[gi]   <= issue_pred_taken;
                     alt_pc[gi] <= issue_alt_pc;
                  end
               end
            end
         end
      end
   endgenerate

   // Head/tail/count bookkeeping; a mispredict empties the buffer outright.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (rdy_in) begin
         if (mispredict) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
         end else begin
            if (do_retire) head <= next_ptr(head);
            if (do_issue)  tail <= next_ptr(tail);
            case ({do_issue, do_retire})
               2'b10:   count <= count + ROB_SIZE_WIDTH'(1);
               2'b01:   count <= count - ROB_SIZE_WIDTH'(1);
               default: count <= count;
            endcase
         end
      end
   end

   // Registered commit interface; strobes are single-cycle, payloads hold.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         commit_valid     <= 1'b0;
         commit_rd        <= '0;
         commit_value     <= '0;
         commit_tag       <= '0;
         store_commit_out <= 1'b0;
         flush_out        <= 1'b0;
         redirect_pc_out  <= '0;
      end else if (rdy_in) begin
         commit_valid     <= 1'b0;
         store_commit_out <= 1'b0;
         flush_out        <= 1'b0;
         if (do_retire) begin
            if (mispredict) begin
               flush_out       <= 1'b1;
               redirect_pc_out <= alt_pc[head];
            end else if (kind[head] == TYPE_STORE) begin
               store_commit_out <= 1'b1;
            end else if (kind[head] != TYPE_BRANCH) begin
               commit_valid <= 1'b1;
               commit_rd    <= rd[head];
               commit_value <= value[head];
               commit_tag   <= head;
            end
         end
      end
   end

   // Operand lookup port 1: a live CDB broadcast wins over the stored value.
   always_comb begin
      query1_ready = 1'b0;
      query1_value = '0;
      if (query1_tag != NONE) begin
         query1_ready = busy[query1_tag] && ready[query1_tag];
         query1_value = value[query1_tag];
      end
      if (cdb_valid && (cdb_tag == query1_tag)) begin
         query1_ready = 1'b1;
         query1_value = cdb_value;
      end
   end

   // Operand lookup port 2: same forwarding rule as port 1.
   always_comb begin
      query2_ready = 1'b0;
      query2_value = '0;
      if (query2_tag != NONE) begin
         query2_ready = busy[query2_tag] && ready[query2_tag];
         query2_value = value[query2_tag];
      end
      if (cdb_valid && (cdb_tag == query2_tag)) begin
         query2_ready = 1'b1;
         query2_value = cdb_value;
      end
   end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer. Expected retire events are queued as
// stimulus is issued; a negedge monitor pops and compares each event the DUT
// presents. Directed checks cover combinational outputs and cycle timing.
module tb_reorder_buffer;

   logic        clk_in = 1'b0;
   logic        rst_in = 1'b1;
   logic        rdy_in = 1'b1;
   logic        issue_valid = 1'b0;
   logic [1:0]  issue_type = 2'd0;
   logic [4:0]  issue_rd = 5'd0;
   logic        issue_pred_taken = 1'b0;
   logic [31:0] issue_alt_pc = 32'd0;
   logic [3:0]  issue_tag_out;
   logic        full_out;
   logic        cdb_valid = 1'b0;
   logic [3:0]  cdb_tag = 4'd0;
   logic [31:0] cdb_value = 32'd0;
   logic        cdb_taken = 1'b0;
   logic [3:0]  query1_tag = 4'hF;
   logic [3:0]  query2_tag = 4'hF;
   logic        query1_ready, query2_ready;
   logic [31:0] query1_value, query2_value;
   logic        commit_valid;
   logic [4:0]  commit_rd;
   logic [31:0] commit_value;
   logic [3:0]  commit_tag;
   logic        store_commit_out;
   logic        flush_out;
   logic [31:0] redirect_pc_out;

   reorder_buffer #(.ROB_SIZE_WIDTH(4), .REG_NUM_WIDTH(5)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
      .issue_valid(issue_valid), .issue_type(issue_type), .issue_rd(issue_rd),
      .issue_pred_taken(issue_pred_taken), .issue_alt_pc(issue_alt_pc),
      .issue_tag_out(issue_tag_out), .full_out(full_out),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value), .cdb_taken(cdb_taken),
      .query1_tag(query1_tag), .query2_tag(query2_tag),
      .query1_ready(query1_ready), .query2_ready(query2_ready),
      .query1_value(query1_value), .query2_value(query2_value),
      .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_value(commit_value),
      .commit_tag(commit_tag), .store_commit_out(store_commit_out),
      .flush_out(flush_out), .redirect_pc_out(redirect_pc_out)
   );

   always #5 clk_in = ~clk_in;

   // kind: 0 = register commit, 1 = store commit, 2 = flush
   typedef struct {
      int          kind;
      logic [4:0]  rd;
      logic [31:0] val;
      logic [3:0]  tag;
      logic [31:0] pc;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail = 0;
   logic last_rdy = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   task automatic cycle();
      @(posedge clk_in);
      #1;
   endtask

   task automatic push_reg(input logic [4:0] rd, input logic [31:0] val, input logic [3:0] tag);
      exp_t e;
      e.kind = 0; e.rd = rd; e.val = val; e.tag = tag; e.pc = 32'd0;
      exp_q.push_back(e);
   endtask

   task automatic push_evt(input int kind, input logic [31:0] pc);
      exp_t e;
      e.kind = kind; e.rd = 5'd0; e.val = 32'd0; e.tag = 4'd0; e.pc = pc;
      exp_q.push_back(e);
   endtask

   task automatic issue(input logic [1:0] ty, input logic [4:0] rd,
                        input logic pred, input logic [31:0] alt, input logic [3:0] exp_tag);
      issue_valid = 1'b1; issue_type = ty; issue_rd = rd;
      issue_pred_taken = pred; issue_alt_pc = alt;
      #1;
      check("issue_tag", {28'd0, issue_tag_out}, {28'd0, exp_tag});
      cycle();
      issue_valid = 1'b0;
      $display("issue type=%0d rd=%0d tag=%0d", ty, rd, exp_tag);
   endtask

   task automatic cdb(input logic [3:0] tag, input logic [31:0] val, input logic tk);
      cdb_valid = 1'b1; cdb_tag = tag; cdb_value = val; cdb_taken = tk;
      cycle();
      cdb_valid = 1'b0;
      $display("cdb tag=%0d value=0x%0h taken=%0d", tag, val, tk);
   endtask

   always @(posedge clk_in) last_rdy <= rdy_in;

   // Monitor: every fresh retire event must match the head of the queue.
   always @(negedge clk_in) begin
      if (last_rdy && (commit_valid || store_commit_out || flush_out)) begin
         exp_t e;
         int   k;
         k = flush_out ? 2 : (store_commit_out ? 1 : 0);
         n_checks++;
         if ((32'(commit_valid) + 32'(store_commit_out) + 32'(flush_out)) > 1) begin
            n_fail++;
            $display("FAIL strobes: valid=%0d store=%0d flush=%0d, expected one-hot",
                     commit_valid, store_commit_out, flush_out);
         end else if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: kind=%0d tag=%0d, expected none", k, commit_tag);
         end else begin
            e = exp_q.pop_front();
            if (k != e.kind) begin
               n_fail++;
               $display("FAIL event_kind: got %0d, expected %0d", k, e.kind);
            end else if (k == 0 && (commit_rd !== e.rd || commit_value !== e.val || commit_tag !== e.tag)) begin
               n_fail++;
               $display("FAIL commit: got rd=%0d val=0x%0h tag=%0d, expected rd=%0d val=0x%0h tag=%0d",
                        commit_rd, commit_value, commit_tag, e.rd, e.val, e.tag);
            end else if (k == 2 && redirect_pc_out !== e.pc) begin
               n_fail++;
               $display("FAIL redirect: got 0x%0h, expected 0x%0h", redirect_pc_out, e.pc);
            end else begin
               $display("retire kind=%0d rd=%0d val=0x%0h tag=%0d pc=0x%0h ok",
                        k, commit_rd, commit_value, commit_tag, redirect_pc_out);
            end
         end
      end
   end

   initial begin
      // ---------------- reset state ----------------
      cycle(); cycle();
      rst_in = 1'b0;
      check("rst_commit_valid", {31'd0, commit_valid}, 32'd0);
      check("rst_commit_rd", {27'd0, commit_rd}, 32'd0);
      check("rst_commit_value", commit_value, 32'd0);
      check("rst_commit_tag", {28'd0, commit_tag}, 32'd0);
      check("rst_store", {31'd0, store_commit_out}, 32'd0);
      check("rst_flush", {31'd0, flush_out}, 32'd0);
      check("rst_redirect", redirect_pc_out, 32'd0);
      check("rst_full", {31'd0, full_out}, 32'd0);

      // ---------------- single REG round trip ----------------
      issue(2'd0, 5'd5, 1'b0, 32'd0, 4'd0);
      push_reg(5'd5, 32'h1234, 4'd0);
      cdb(4'd0, 32'h1234, 1'b0);
      cycle();
      check("rt_commit_valid", {31'd0, commit_valid}, 32'd1);
      check("rt_commit_rd", {27'd0, commit_rd}, 32'd5);
      cycle();
      check("rt_commit_drop", {31'd0, commit_valid}, 32'd0);
      check("rt_rd_hold", {27'd0, commit_rd}, 32'd5);

      // ---------------- fill to capacity ----------------
      rst_in = 1'b1; cycle(); rst_in = 1'b0;
      for (int i = 0; i < 15; i++) begin
         check("not_full", {31'd0, full_out}, 32'd0);
         issue(2'd0, 5'(i + 1), 1'b0, 32'd0, 4'(i));
      end
      check("full_after_15", {31'd0, full_out}, 32'd1);
      check("tail_wrapped", {28'd0, issue_tag_out}, 32'd0);
      issue(2'd0, 5'd31, 1'b0, 32'd0, 4'd0);
      check("full_after_drop", {31'd0, full_out}, 32'd1);
      check("tail_after_drop", {28'd0, issue_tag_out}, 32'd0);
      for (int i = 14; i >= 0; i--) cdb(4'(i), 32'h100 + 32'(i), 1'b0);
      for (int i = 0; i < 15; i++) push_reg(5'(i + 1), 32'h100 + 32'(i), 4'(i));
      for (int i = 0; i < 15; i++) begin
         // The first retiring cycle is still full: this issue must be dropped.
         issue_valid = (i == 0); issue_type = 2'd0; issue_rd = 5'd30;
         cycle();
         issue_valid = 1'b0;
         check("burst_valid", {31'd0, commit_valid}, 32'd1);
         check("burst_tag", {28'd0, commit_tag}, 32'(i));
      end
      cycle();
      check("burst_end", {31'd0, commit_valid}, 32'd0);
      check("wrap_tag0", {28'd0, issue_tag_out}, 32'd0);
      check("wrap_not_full", {31'd0, full_out}, 32'd0);

      // ---------------- out-of-order CDB ----------------
      issue(2'd0, 5'd10, 1'b0, 32'd0, 4'd0);
      issue(2'd0, 5'd11, 1'b0, 32'd0, 4'd1);
      issue(2'd0, 5'd12, 1'b0, 32'd0, 4'd2);
      cdb(4'd2, 32'hA2, 1'b0);
      cdb(4'd1, 32'hA1, 1'b0);
      cycle(); cycle();
      check("ooo_wait", {31'd0, commit_valid}, 32'd0);
      push_reg(5'd10, 32'hA0, 4'd0);
      push_reg(5'd11, 32'hA1, 4'd1);
      push_reg(5'd12, 32'hA2, 4'd2);
      cdb(4'd0, 32'hA0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cycle();
         check("ooo_tag", {28'd0, commit_tag}, 32'(i));
         check("ooo_valid", {31'd0, commit_valid}, 32'd1);
      end
      cycle();

      // ---------------- mispredict ----------------
      issue(2'd1, 5'd0, 1'b0, 32'h80, 4'd3);
      issue(2'd0, 5'd1, 1'b0, 32'd0, 4'd4);
      issue(2'd0, 5'd2, 1'b0, 32'd0, 4'd5);
      push_evt(2, 32'h80);
      cdb(4'd3, 32'd0, 1'b1);
      // Issue and CDB alongside the flush are both discarded.
      issue_valid = 1'b1; issue_type = 2'd0; issue_rd = 5'd9;
      cdb_valid = 1'b1; cdb_tag = 4'd4; cdb_value = 32'hDEAD;
      cycle();
      issue_valid = 1'b0; cdb_valid = 1'b0;
      check("flush_pulse", {31'd0, flush_out}, 32'd1);
      check("flush_pc", redirect_pc_out, 32'h80);
      check("flush_no_commit", {31'd0, commit_valid}, 32'd0);
      check("flush_tag0", {28'd0, issue_tag_out}, 32'd0);
      cycle();
      check("flush_drop", {31'd0, flush_out}, 32'd0);

      // ---------------- store + correct branch after flush ----------------
      issue(2'd2, 5'd0, 1'b0, 32'd0, 4'd0);
      check("count_one", {28'd0, issue_tag_out}, 32'd1);
      issue(2'd1, 5'd0, 1'b1, 32'h200, 4'd1);
      issue(2'd0, 5'd7, 1'b0, 32'd0, 4'd2);
      push_evt(1, 32'd0);
      push_reg(5'd7, 32'h77, 4'd2);
      cdb(4'd2, 32'h77, 1'b0);
      cdb(4'd1, 32'd0, 1'b1);
      cdb(4'd0, 32'h5, 1'b0);
      cycle();
      check("store_pulse", {31'd0, store_commit_out}, 32'd1);
      cycle();
      check("branch_ok_quiet", {29'd0, commit_valid, store_commit_out, flush_out}, 32'd0);
      cycle(); cycle();

      // ---------------- query forwarding ----------------
      rst_in = 1'b1; cycle(); rst_in = 1'b0;
      for (int i = 0; i < 4; i++) issue(2'd0, 5'(20 + i), 1'b0, 32'd0, 4'(i));
      query1_tag = 4'd3; query2_tag = 4'd2;
      cdb_valid = 1'b1; cdb_tag = 4'd3; cdb_value = 32'hBEEF; cdb_taken = 1'b0;
      #1;
      check("q1_fwd_ready", {31'd0, query1_ready}, 32'd1);
      check("q1_fwd_value", query1_value, 32'hBEEF);
      check("q2_not_ready", {31'd0, query2_ready}, 32'd0);
      cycle();
      cdb_valid = 1'b0;
      #1;
      check("q1_stored_ready", {31'd0, query1_ready}, 32'd1);
      check("q1_stored_value", query1_value, 32'hBEEF);
      cdb_valid = 1'b1; cdb_tag = 4'd3; cdb_value = 32'hCAFE;
      #1;
      check("q1_cdb_priority", query1_value, 32'hCAFE);
      cdb_valid = 1'b0;
      #1;

      // ---------------- rdy_in freeze ----------------
      cdb(4'd1, 32'h51, 1'b0);
      push_reg(5'd20, 32'h50, 4'd0);
      push_reg(5'd21, 32'h51, 4'd1);
      cdb(4'd0, 32'h50, 1'b0);
      cycle();
      check("pre_freeze_tag", {28'd0, commit_tag}, 32'd0);
      rdy_in = 1'b0;
      issue_valid = 1'b1; issue_type = 2'd0; issue_rd = 5'd29;
      for (int i = 0; i < 3; i++) begin
         cycle();
         check("frz_valid", {31'd0, commit_valid}, 32'd1);
         check("frz_tag", {28'd0, commit_tag}, 32'd0);
         check("frz_value", commit_value, 32'h50);
      end
      issue_valid = 1'b0;
      #1;
      check("frz_tail", {28'd0, issue_tag_out}, 32'd4);
      rdy_in = 1'b1;
      cycle();
      check("thaw_tag", {28'd0, commit_tag}, 32'd1);
      cycle();
      check("thaw_stall", {31'd0, commit_valid}, 32'd0);

      // ---------------- reset with 4 entries pending ----------------
      issue(2'd0, 5'd24, 1'b0, 32'd0, 4'd4);
      issue(2'd1, 5'd0, 1'b0, 32'h300, 4'd5);
      rst_in = 1'b1;
      cdb_valid = 1'b1; cdb_tag = 4'd2; cdb_value = 32'h99;
      cycle();
      rst_in = 1'b0; cdb_valid = 1'b0;
      check("mid_rst_valid", {31'd0, commit_valid}, 32'd0);
      check("mid_rst_value", commit_value, 32'd0);
      check("mid_rst_tag", {28'd0, commit_tag}, 32'd0);
      check("mid_rst_flush", {31'd0, flush_out}, 32'd0);
      check("mid_rst_full", {31'd0, full_out}, 32'd0);
      check("mid_rst_tail", {28'd0, issue_tag_out}, 32'd0);
      for (int i = 0; i < 4; i++) begin
         cycle();
         check("post_rst_quiet", {29'd0, commit_valid, store_commit_out, flush_out}, 32'd0);
      end

      cycle(); cycle();
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular in-order reorder buffer for the out-of-order RISC-V core.
- Allocates tags to instructions issued by the decoder and collects results from the common data bus (CDB).
- Retires one instruction per cycle in program order.
- Drives the register-file commit interface (valid/rd/value/tag) and the pipeline-wide flush on branch mispredict.

Parameters:
ROB_SIZE_WIDTH, 4, tag width. All-ones tag is reserved as "no dependency", so capacity is 2^W-1 (15 entries).
REG_NUM_WIDTH, 5, architectural register index width.

Ports:
clk_in  in  1  clock
rst_in  in  1  reset
rdy_in  in  1  global ready; low freezes all state and outputs
issue_valid  in  1  decoder allocates an entry this cycle
issue_type  in  2  0=REG write, 1=BRANCH, 2=STORE, 3=reserved (treated as REG)
issue_rd  in  REG_NUM_WIDTH  destination register (REG only)
issue_pred_taken  in  1  predicted direction (BRANCH only)
issue_alt_pc  in  32  redirect target if the prediction is wrong
issue_tag_out  out  ROB_SIZE_WIDTH  tag granted to the current issue; combinational, equals tail
full_out  out  1  combinational, count == 2^W-1
cdb_valid  in  1  result broadcast
cdb_tag  in  ROB_SIZE_WIDTH  producing entry
cdb_value  in  32  result value
cdb_taken  in  1  resolved branch direction
query1_tag / query2_tag  in  ROB_SIZE_WIDTH  operand lookups
query1_ready / query2_ready  out  1  combinational: entry busy and ready, or cdb_valid && cdb_tag match
query1_value / query2_value  out  32  combinational; CDB value has priority over stored value
commit_valid  out  1  register-file write strobe
commit_rd  out  REG_NUM_WIDTH  register-file write index
commit_value  out  32  register-file write value
commit_tag  out  ROB_SIZE_WIDTH  tag used by the register file to clear its dependency
store_commit_out  out  1  one-cycle pulse, head STORE retired
flush_out  out  1  one-cycle pulse, mispredict
redirect_pc_out  out  32  fetch redirect target, valid when flush_out=1

Behaviour:
- Reset is synchronous and active-high on rst_in, sampled at posedge clk_in; single clock domain.
- Reset state:
  - head=tail=count=0; all entries not busy.
  - Every registered output is 0 (commit_valid, commit_rd, commit_value, commit_tag, store_commit_out, flush_out, redirect_pc_out).
- Reset mid-operation discards all entries with no commit or flush pulse.
- rdy_in=0: no state change; registered outputs hold their values.
- Pointers wrap from 2^W-2 to 0. Tag 2^W-1 is never allocated.
- Issue (registered):
  - If issue_valid && !full_out, write the entry at tail: busy=1, ready=0, and type/rd/pred/alt_pc from the issue inputs. Then tail++ and count++.
  - Issue while full is dropped silently; the decoder must gate on full_out.
  - A commit in the same cycle does not free space for that cycle's issue.
- CDB:
  - If cdb_valid and entry[cdb_tag] is busy, set ready=1 and latch value and taken.
  - CDB to a non-busy tag is ignored.
- Commit (one per cycle): if count>0 and the head entry is busy and ready, retire it. Registered outputs for the next cycle:
  - REG: commit_valid=1 with rd/value/tag. rd=0 is still strobed; the register file ignores x0.
  - STORE: store_commit_out=1; commit_valid=0.
  - BRANCH with taken==pred_taken: no pulses.
  - BRANCH with taken!=pred_taken: flush_out=1, redirect_pc_out=alt_pc. All entries are cleared and head=tail=count=0 at that edge. A simultaneous issue is discarded; a simultaneous CDB write is discarded.
  - On retire: head++ and count--, except on flush.
- Outputs with no commit that cycle: commit_valid, store_commit_out and flush_out are 0. commit_rd, commit_value, commit_tag and redirect_pc_out keep their last values.
- Issue and commit in the same cycle leave count unchanged.
- Empty buffer: nothing retires even if cdb_valid is asserted.

Test Plan:
- Reset then issue REG rd=5 -> issue_tag_out=0. Then cdb tag0 value 0x1234 -> next cycle commit_valid=1, rd=5, value=0x1234, tag=0. Following cycle commit_valid=0.
- Issue 15 REG entries -> full_out=1 after the 15th. 16th issue is dropped; tail stays 15-wrapped to 0. After writing results to all entries and waiting, tags 0..14 retire in order over 15 consecutive cycles, then the pointers wrap and a new issue gets tag 0.
- Out-of-order CDB: issue tags 0,1,2; results written to 2, then 1, then 0 -> no commit until tag0 is ready, then commits on 3 consecutive cycles in order 0,1,2.
- Mispredict: issue BRANCH pred=0 alt_pc=0x80, then two REG entries; CDB tag0 taken=1 -> flush_out=1, redirect_pc_out=0x80, no commit_valid. Next issue receives tag 0 and count=1.
- query1_tag=3 while cdb_valid with tag 3 and value 0xBEEF, entry not yet ready -> query1_ready=1 and query1_value=0xBEEF in the same cycle.
- rdy_in=0 for 3 cycles with a ready head -> no retire and outputs frozen. Asserting rst_in with 4 entries pending -> all outputs 0 next cycle, full_out=0, and no flush_out pulse.
